// File: rtl/lfsr_spike_encoder_if.sv
// Spike encoder stimulus/config and spike/rate bundle.
// Master drives en/seed/prob; slave returns spike/rate.
interface lfsr_spike_encoder_if #(
  parameter int N_CH   = 4,
  parameter int LFSR_W = 16,
  parameter int PROB_W = 8,
  parameter int CNT_W  = 16
);
  logic                    en;
  logic                    seed_load;
  logic [LFSR_W-1:0]       seed;
  logic [N_CH*PROB_W-1:0]  prob;
  logic [N_CH-1:0]         spike;
  logic [N_CH*CNT_W-1:0]   rate;
  logic                    rate_valid;

  modport master (
    output en, seed_load, seed, prob,
    input  spike, rate, rate_valid
  );

  modport slave (
    input  en, seed_load, seed, prob,
    output spike, rate, rate_valid
  );
endinterface

// File: rtl/lfsr_spike_encoder.sv
// Per-channel Galois LFSR Bernoulli spike encoder with windowed rate count.
// Define SPIKE_REFRAC_EN to add a per-channel refractory period.
module lfsr_spike_encoder #(
  parameter int N_CH   = 4,
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS     = 16'hB400,
  parameter logic [LFSR_W-1:0] RST_SEED = 16'h0001,
  parameter int PROB_W = 8,
  parameter int WINDOW = 256,
  parameter int CNT_W  = 16,
  parameter int REFRAC = 2
) (
  input logic clk,
  input logic rst,
  lfsr_spike_encoder_if.slave bus
);
  localparam int WIN_W = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef logic [LFSR_W-1:0] lfsr_t;

  logic [N_CH-1:0][LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [N_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d, cnt_n;
  logic [N_CH-1:0][CNT_W-1:0]  rate_q, rate_d;
  logic [N_CH-1:0][PROB_W-1:0] prob_v;
  logic [N_CH-1:0]             spike_q, spike_d, fire;
  logic [WIN_W-1:0]            win_q, win_d;
  logic                        rv_q, rv_d;
  lfsr_t                       seed_eff;

`ifdef SPIKE_REFRAC_EN
  localparam int RF_W = $clog2(REFRAC + 1) + 1;
  logic [N_CH-1:0][RF_W-1:0] refr_q, refr_d;
`endif

  function automatic lfsr_t rotl(input lfsr_t x, input int s);
    lfsr_t r;
    r = x;
    for (int i = 0; i < LFSR_W; i++)
      if (i < (s % LFSR_W))
        r = {r[LFSR_W-2:0], r[LFSR_W-1]};
    return r;
  endfunction

  function automatic lfsr_t step(input lfsr_t x);
    return (x >> 1) ^ (x[0] ? TAPS : '0);
  endfunction

  assign prob_v         = bus.prob;
  assign seed_eff       = (bus.seed == '0) ? RST_SEED : bus.seed;
  assign bus.spike      = spike_q;
  assign bus.rate       = rate_q;
  assign bus.rate_valid = rv_q;

  always_comb begin
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    cnt_n   = cnt_q;
    rate_d  = rate_q;
    win_d   = win_q;
    spike_d = '0;
    fire    = '0;
    rv_d    = 1'b0;
`ifdef SPIKE_REFRAC_EN
    refr_d  = refr_q;
`endif
    if (bus.seed_load) begin
      for (int c = 0; c < N_CH; c++)
        lfsr_d[c] = rotl(seed_eff, c);
      cnt_d = '0;
      win_d = '0;
`ifdef SPIKE_REFRAC_EN
      refr_d = '0;
`endif
    end else if (bus.en) begin
      for (int c = 0; c < N_CH; c++) begin
        // compare uses the pre-step LFSR state
        fire[c] = lfsr_q[c][PROB_W-1:0] < prob_v[c];
`ifdef SPIKE_REFRAC_EN
        if (refr_q[c] != '0) begin
          fire[c]   = 1'b0;
          refr_d[c] = refr_q[c] - RF_W'(1);
        end else if (fire[c]) begin
          refr_d[c] = RF_W'(REFRAC);
        end
`endif
        lfsr_d[c] = step(lfsr_q[c]);
        if (fire[c] && cnt_q[c] != CNT_MAX)
          cnt_n[c] = cnt_q[c] + CNT_W'(1);
      end
      spike_d = fire;
      if (win_q == WIN_LAST) begin
        rate_d = cnt_n;
        rv_d   = 1'b1;
        cnt_d  = '0;
        win_d  = '0;
      end else begin
        cnt_d = cnt_n;
        win_d = win_q + WIN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < N_CH; c++)
        lfsr_q[c] <= rotl(RST_SEED, c);
      cnt_q   <= '0;
      rate_q  <= '0;
      spike_q <= '0;
      win_q   <= '0;
      rv_q    <= 1'b0;
`ifdef SPIKE_REFRAC_EN
      refr_q  <= '0;
`endif
    end else begin
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      rate_q  <= rate_d;
      spike_q <= spike_d;
      win_q   <= win_d;
      rv_q    <= rv_d;
`ifdef SPIKE_REFRAC_EN
      refr_q  <= refr_d;
`endif
    end
  end
endmodule

// File: tb/tb_lfsr_spike_encoder.sv
// Scoreboard bench for lfsr_spike_encoder (WINDOW=16, CNT_W=3).
// Reference model predicts spike/rate/rate_valid for every driven cycle.
module tb_lfsr_spike_encoder;
  localparam int N_CH = 4;
  localparam int CW   = 3;
  localparam int REFR = 2;

  typedef struct packed {
    logic [N_CH-1:0]    spike;
    logic [N_CH*CW-1:0] rate;
    logic               rv;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   rv_seen = 0;
  exp_t sbq[$];

  logic [15:0] m_lfsr[N_CH];
  int          m_cnt[N_CH];
  int          m_rate[N_CH];
  int          m_refr[N_CH];
  int          m_win;

  lfsr_spike_encoder_if #(
    .N_CH(N_CH), .LFSR_W(16), .PROB_W(8), .CNT_W(CW)
  ) bus ();

  lfsr_spike_encoder #(
    .N_CH(N_CH), .LFSR_W(16), .TAPS(16'hB400),
    .RST_SEED(16'h0001), .PROB_W(8), .WINDOW(16),
    .CNT_W(CW), .REFRAC(REFR)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_rotl(input logic [15:0] x,
                                         input int s);
    logic [31:0] d;
    d = {x, x} << s;
    return d[31:16];
  endfunction

  function automatic logic [15:0] m_step(input logic [15:0] x);
    logic [15:0] n;
    n = {1'b0, x[15:1]};
    if (x[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_lfsr[c] = m_rotl(16'h0001, c);
      m_cnt[c]  = 0;
      m_rate[c] = 0;
      m_refr[c] = 0;
    end
    m_win = 0;
  endtask

  task automatic drive(input logic e, input logic sl,
                       input logic [15:0] sd,
                       input logic [31:0] pr);
    exp_t x;
    logic f;
    logic [7:0] p;
    @(negedge clk);
    bus.en = e;
    bus.seed_load = sl;
    bus.seed = sd;
    bus.prob = pr;
    x.spike = '0;
    x.rv = 1'b0;
    if (sl) begin
      for (int c = 0; c < N_CH; c++) begin
        m_lfsr[c] = m_rotl((sd == 16'h0) ? 16'h0001 : sd, c);
        m_cnt[c] = 0;
        m_refr[c] = 0;
      end
      m_win = 0;
    end else if (e) begin
      for (int c = 0; c < N_CH; c++) begin
        p = pr[c*8 +: 8];
        f = (m_lfsr[c][7:0] < p);
`ifdef SPIKE_REFRAC_EN
        if (m_refr[c] > 0) begin
          f = 1'b0;
          m_refr[c]--;
        end else if (f) begin
          m_refr[c] = REFR;
        end
`endif
        x.spike[c] = f;
        if (f && m_cnt[c] < (1 << CW) - 1) m_cnt[c]++;
        m_lfsr[c] = m_step(m_lfsr[c]);
      end
      if (m_win == 15) begin
        for (int c = 0; c < N_CH; c++) begin
          m_rate[c] = m_cnt[c];
          m_cnt[c] = 0;
        end
        x.rv = 1'b1;
        m_win = 0;
      end else begin
        m_win++;
      end
    end
    for (int c = 0; c < N_CH; c++)
      x.rate[c*CW +: CW] = CW'(m_rate[c]);
    sbq.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst && sbq.size() > 0) begin
      exp_t x;
      x = sbq.pop_front();
      chk("spike", 32'(bus.spike), 32'(x.spike));
      chk("rate", 32'(bus.rate), 32'(x.rate));
      chk("rate_valid", 32'(bus.rate_valid), 32'(x.rv));
      if (bus.rate_valid) rv_seen++;
    end
  end

  initial begin
    int rv0;
    int tries;
    bus.en = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed = '0;
    bus.prob = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_spike", 32'(bus.spike), 32'h0);
    chk("rst_rate", 32'(bus.rate), 32'h0);
    chk("rst_rv", 32'(bus.rate_valid), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 40; i++)
      drive(1'b1, 1'b0, 16'h0, 32'h80808080);

    drive(1'b0, 1'b1, 16'h0001, 32'h0);
    rv0 = rv_seen;
    for (int i = 0; i < 32; i++)
      drive(1'b1, 1'b0, 16'h0, 32'h0);
    @(posedge clk);
    #2;
    chk("rv_pulses", 32'(rv_seen - rv0), 32'd2);

    drive(1'b0, 1'b1, 16'h0001, 32'h0);
    for (int i = 0; i < 100; i++)
      drive(1'b1, 1'b0, 16'h0, 32'hFF014080);

    drive(1'b0, 1'b1, 16'h0000, 32'h0);
    for (int i = 0; i < 40; i++)
      drive(1'($urandom_range(0, 2) != 0), 1'b0, 16'h0,
            32'h80808080);

    drive(1'b0, 1'b1, 16'hACE1, 32'h0);
    for (int i = 0; i < 48; i++)
      drive(1'b1, 1'b0, 16'h0, 32'hFFFFFFFF);

    for (int i = 0; i < 9; i++)
      drive(1'b1, 1'b0, 16'h0, 32'hFFFFFFFF);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_spike", 32'(bus.spike), 32'h0);
    chk("mid_rst_rate", 32'(bus.rate), 32'h0);
    chk("mid_rst_rv", 32'(bus.rate_valid), 32'h0);
    m_reset();
    bus.en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 24; i++)
      drive(1'b1, 1'b0, 16'h0, 32'hC0804010);

    for (int i = 0; i < 80; i++)
      drive(1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 29) == 0),
            16'($urandom), $urandom);

    drive(1'b0, 1'b0, 16'h0, 32'h0);
    tries = 0;
    while (sbq.size() > 0 && tries < 10) begin
      @(posedge clk);
      tries++;
    end
    #2;
    chk("drain", 32'(sbq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
